// File: rtl/router_out_reader.sv
// Reader-side consumer for one router output port: drains the FIFO, parses
// header/payload/parity, streams payload downstream and keeps statistics.
module router_out_reader #(
  parameter int unsigned PORT_ID   = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vld_out,
  input  logic                 soft_reset,
  input  logic [7:0]           data_out,
  output logic                 read_enb,
  input  logic                 pkt_ready,
  output logic [7:0]           pkt_data,
  output logic                 pkt_valid,
  output logic                 pkt_sop,
  output logic                 pkt_eop,
  output logic [5:0]           pkt_len,
  output logic [1:0]           pkt_addr,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic                 pkt_abort,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [1:0] PORT_ADDR = 2'(PORT_ID);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  state_t      state, state_next;
  logic        need_issue;
  logic        cap;        // a read was issued last cycle, data_out is valid now
  logic [6:0]  rem_issue;
  logic [6:0]  rem_cap;
  logic [7:0]  par_acc;
  logic        first;
  logic        perr_now, aerr_now;

  assign perr_now = (par_acc != data_out);
  assign aerr_now = (pkt_addr != PORT_ADDR);

  always_comb begin
    need_issue = 1'b0;
    state_next = state;
    case (state)
      IDLE:    need_issue = 1'b1;
      BODY:    need_issue = (rem_issue != '0);
      default: need_issue = 1'b0;
    endcase
    read_enb = vld_out & pkt_ready & ~soft_reset & need_issue & ~reset;
    case (state)
      IDLE:    if (read_enb) state_next = HDR;
      HDR:     if (cap) state_next = BODY;
      BODY:    if (cap && rem_cap == 7'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (soft_reset && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap        <= 1'b0;
      rem_issue  <= '0;
      rem_cap    <= '0;
      par_acc    <= '0;
      first      <= 1'b0;
      pkt_data   <= '0;
      pkt_valid  <= 1'b0;
      pkt_sop    <= 1'b0;
      pkt_eop    <= 1'b0;
      pkt_len    <= '0;
      pkt_addr   <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      cap        <= read_enb;
      pkt_valid  <= 1'b0;
      pkt_sop    <= 1'b0;
      pkt_eop    <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
      // A soft reset kills the packet; any capture landing this cycle is dropped.
      if (soft_reset && state != IDLE) begin
        pkt_abort <= 1'b1;
      end else begin
        case (state)
          HDR: begin
            if (cap) begin
              pkt_len   <= data_out[7:2];
              pkt_addr  <= data_out[1:0];
              par_acc   <= data_out;
              rem_issue <= {1'b0, data_out[7:2]} + 7'd1;
              rem_cap   <= {1'b0, data_out[7:2]} + 7'd1;
              first     <= 1'b1;
            end
          end
          BODY: begin
            if (read_enb) rem_issue <= rem_issue - 7'd1;
            if (cap) begin
              rem_cap <= rem_cap - 7'd1;
              if (rem_cap > 7'd1) begin
                par_acc   <= par_acc ^ data_out;
                pkt_data  <= data_out;
                pkt_valid <= 1'b1;
                pkt_sop   <= first;
                pkt_eop   <= (rem_cap == 7'd2);
                first     <= 1'b0;
              end else begin
                pkt_done   <= 1'b1;
                parity_err <= perr_now;
                addr_err   <= aerr_now;
                if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
                if ((perr_now || aerr_now) && err_count != '1)
                  err_count <= err_count + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
